memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 26 ++
 rtl/memory_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared types and constants for the iCache/dCache main-memory arbiter.
//   state_t          : arbiter FSM encoding (IDLE / BUSY / RESP)
//   LINE_OFFSET_BITS : byte-offset bits inside a cache line, zeroed on MemAddr
//   arb_pick_d       : arbitration decision (1 = grant the dCache)
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LINE_OFFSET_BITS = 4;

    // dCache has priority, except right after a D grant while the iCache is
    // waiting: then the iCache goes first so neither side can be starved.
    function automatic logic arb_pick_d(input logic el_i,
                                        input logic el_d,
                                        input logic last_d);
        return el_d & ~(last_d & el_i);
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Arbitrates iCache line fills and dCache fills/writebacks onto a single
// main-memory port, one request outstanding at a time.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   IReq, IAddr            : iCache fill request (level) and miss address
//   IReady, IData          : one-cycle completion pulse, returned line (held)
//   DReq, DWrite, DAddr,
//   DWData                 : dCache request (fill or writeback), addr, data
//   DReady, DRData         : one-cycle completion pulse, returned line (held)
//   MemReq, MemWrite,
//   MemAddr, MemWData      : registered main-memory request (line aligned)
//   MemReady, MemRData     : memory completion pulse and read line
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IReq,
    input  logic [WORD_SIZE-1:0] IAddr,
    output logic                 IReady,
    output logic [LINE_SIZE-1:0] IData,
    input  logic                 DReq,
    input  logic                 DWrite,
    input  logic [WORD_SIZE-1:0] DAddr,
    input  logic [LINE_SIZE-1:0] DWData,
    output logic                 DReady,
    output logic [LINE_SIZE-1:0] DRData,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [LINE_SIZE-1:0] MemWData,
    input  logic                 MemReady,
    input  logic [LINE_SIZE-1:0] MemRData
);

    localparam logic [WORD_SIZE-1:0] ALIGN_MASK =
        {{(WORD_SIZE-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_gnt_d;      // grant of the current/most recent transaction
    logic [LINE_SIZE-1:0] r_line;       // line captured from memory, pending RESP
    logic                 w_el_i;
    logic                 w_el_d;
    logic                 w_capture;
    logic                 w_pick_d;

    // A Ready pulse is high exactly in the IDLE cycle following RESP, so it
    // masks the just-served requester whose Req has not had time to drop.
    assign w_el_i = IReq & ~IReady;
    assign w_el_d = DReq & ~DReady;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and capture/arbitration decision
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_pick_d     = r_gnt_d;
        case (r_state)
            ST_IDLE: begin
                if (w_el_i || w_el_d) begin
                    w_capture    = 1'b1;
                    w_pick_d     = arb_pick_d(w_el_i, w_el_d, r_gnt_d);
                    w_next_state = ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (MemReady) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Memory-side request registers: loaded on capture, MemReq cleared on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_d  <= 1'b0;
            MemReq   <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= {WORD_SIZE{1'b0}};
            MemWData <= {LINE_SIZE{1'b0}};
            r_line   <= {LINE_SIZE{1'b0}};
        end else begin
            if (w_capture) begin
                r_gnt_d  <= w_pick_d;
                MemReq   <= 1'b1;
                MemWrite <= w_pick_d & DWrite;
                MemAddr  <= (w_pick_d ? DAddr : IAddr) & ALIGN_MASK;
                if (w_pick_d && DWrite) begin
                    MemWData <= DWData;
                end
            end else if ((r_state == ST_BUSY) && MemReady) begin
                MemReq <= 1'b0;
                r_line <= MemRData;
            end
        end
    end

    // Requester-side response: one-cycle Ready pulse, data held between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            IData  <= {LINE_SIZE{1'b0}};
            DRData <= {LINE_SIZE{1'b0}};
        end else begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            if (r_state == ST_RESP) begin
                if (r_gnt_d) begin
                    DReady <= 1'b1;
                    // writebacks return no data; keep the last filled line
                    if (!MemWrite) begin
                        DRData <= r_line;
                    end
                end else begin
                    IReady <= 1'b1;
                    IData  <= r_line;
                end
            end
        end
    end

endmodule
